// File: rtl/digit_scan_pkg.sv
// Shared types and constants for the four-digit display scan controller.
// Holds the FSM state encoding, digit/select widths and the anode helper.
// Imported by the interface, the next-digit selector and the top level.
package digit_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam int N_DIGITS = 4;
  localparam int CTRL_W   = 2;
  localparam logic [N_DIGITS-1:0] ANODE_OFF = 4'b1111;

  // Active-low one-hot anode pattern that lights only digit idx.
  function automatic logic [N_DIGITS-1:0] anode_on(input logic [CTRL_W-1:0] idx);
    anode_on = ~(N_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Bundle of scan-enable/mask inputs and the display-drive outputs.
// master = the side that enables the scan and watches the display.
// slave  = the scan controller itself.
interface digit_scan_ctrl_if;
  import digit_scan_pkg::*;

  logic                i_en;
  logic [N_DIGITS-1:0] i_digit_mask;
  logic [CTRL_W-1:0]   o_ctrl;
  logic [N_DIGITS-1:0] o_anode;
  logic                o_frame_tick;

  modport master (
    output i_en,
    output i_digit_mask,
    input  o_ctrl,
    input  o_anode,
    input  o_frame_tick
  );

  modport slave (
    input  i_en,
    input  i_digit_mask,
    output o_ctrl,
    output o_anode,
    output o_frame_tick
  );

endinterface

// File: rtl/digit_scan_ctrl_next_digit_sel.sv
// Rotate-priority encoder: first enabled digit strictly after cur, wrapping.
// Purely combinational, zero latency.
// wrap is set when the chosen index is not above cur (scan restarted a frame).
module next_digit_sel
  import digit_scan_pkg::*;
(
  input  logic [CTRL_W-1:0]   cur,
  input  logic [N_DIGITS-1:0] mask,
  output logic [CTRL_W-1:0]   nxt,
  output logic                wrap
);

  logic [CTRL_W-1:0] probe;
  logic              found;

  // Search cur+1, cur+2, cur+3 and finally cur itself; modulo-4 via width wrap.
  always_comb begin
    nxt   = cur;
    probe = cur;
    found = 1'b0;
    for (int k = 1; k <= N_DIGITS; k++) begin
      probe = cur + CTRL_W'(k);
      if (!found && mask[probe]) begin
        nxt   = probe;
        found = 1'b1;
      end
    end
    wrap = (nxt <= cur);
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Round-robin scan of enabled display digits with dwell time and blanking gap.
// All outputs registered; o_ctrl changes only on entry to BLANK.
// No backpressure: i_en low or empty mask drops to IDLE with anodes off.
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  digit_scan_ctrl_if.slave  bus
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CTRL_W-1:0]   ctrl;
  logic [N_DIGITS-1:0] anode;
  logic                frame_tick;

  logic                en;
  logic [N_DIGITS-1:0] mask;
  logic [CTRL_W-1:0]   sel_cur;
  logic [CTRL_W-1:0]   sel_nxt;
  logic                sel_wrap;

  assign en   = bus.i_en;
  assign mask = bus.i_digit_mask;

  // From IDLE, searching "after digit 3" yields the lowest enabled digit.
  assign sel_cur = (state == ST_IDLE) ? CTRL_W'(N_DIGITS - 1) : ctrl;

  next_digit_sel u_sel (
    .cur  (sel_cur),
    .mask (mask),
    .nxt  (sel_nxt),
    .wrap (sel_wrap)
  );

  // Scan FSM with registered select, anode and frame-tick outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ctrl       <= '0;
      anode      <= ANODE_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (!en) begin
        state <= ST_IDLE;
        cnt   <= '0;
        anode <= ANODE_OFF;
      end else begin
        case (state)
          ST_IDLE: begin
            anode <= ANODE_OFF;
            cnt   <= '0;
            if (mask != '0) begin
              state <= ST_BLANK;
              ctrl  <= sel_nxt;
            end
          end
          ST_BLANK, ST_SHOW: begin
            if (mask == '0) begin
              state <= ST_IDLE;
              cnt   <= '0;
              anode <= ANODE_OFF;
            end else if (!mask[ctrl]) begin
              // Current digit withdrawn: move on at once rather than finish the slot.
              state      <= ST_BLANK;
              ctrl       <= sel_nxt;
              frame_tick <= sel_wrap;
              cnt        <= '0;
              anode      <= ANODE_OFF;
            end else if (state == ST_BLANK) begin
              if (cnt == BLANK_LAST) begin
                state <= ST_SHOW;
                cnt   <= '0;
                anode <= anode_on(ctrl);
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              if (cnt == DWELL_LAST) begin
                state      <= ST_BLANK;
                ctrl       <= sel_nxt;
                frame_tick <= sel_wrap;
                cnt        <= '0;
                anode      <= ANODE_OFF;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
            anode <= ANODE_OFF;
          end
        endcase
      end
    end
  end

  assign bus.o_ctrl       = ctrl;
  assign bus.o_anode      = anode;
  assign bus.o_frame_tick = frame_tick;

endmodule
